// File: rtl/omega_network_sr.sv
// Buffered omega (shuffle-exchange) network: S stages of 2x2 round-robin switches with one-entry registers.
// Define OMEGA_NETWORK_SR_STATS_EN to add the saturating conflict_count output.
module omega_network_sr #(
  parameter int WIDTH            = 8,
  parameter int IN_PORTS         = 8,
  parameter int ADDR_WIDTH_PORTS = $clog2(IN_PORTS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [0:IN_PORTS-1]                  push,
  input  logic [IN_PORTS*WIDTH-1:0]            d_in,
  input  logic [IN_PORTS*ADDR_WIDTH_PORTS-1:0] addr_in,
  output logic [0:IN_PORTS-1]                  ready,
  output logic [0:IN_PORTS-1]                  valid,
  output logic [IN_PORTS*WIDTH-1:0]            d_out,
  input  logic [0:IN_PORTS-1]                  pop
`ifdef OMEGA_NETWORK_SR_STATS_EN
  ,output logic [15:0]                         conflict_count
`endif
);
  localparam int N  = IN_PORTS;
  localparam int S  = ADDR_WIDTH_PORTS;
  localparam int AW = ADDR_WIDTH_PORTS;

  // Layer 0 holds the input registers, layer s+1 the outputs of stage s; layer S drives the ports.
  logic [S:0][N-1:0]            vld_q, vld_d, adv;
  logic [S:0][N-1:0][WIDTH-1:0] dat_q, dat_d;
  logic [S-1:0][N-1:0][AW-1:0]  adr_q, adr_d;
  logic [S-1:0][N-1:0]          rr_q, rr_d;
`ifdef OMEGA_NETWORK_SR_STATS_EN
  logic [15:0] nconf;
`endif

  // Source position feeding switch input j: inverse of the perfect shuffle (rotate right).
  function automatic int unshuf(input int j);
    return (j >> 1) | ((j & 1) << (S - 1));
  endfunction

  always_comb begin
    int  qu, ql, g;
    logic ru, rl;
    qu = 0; ql = 0; g = 0; ru = 1'b0; rl = 1'b0;
    vld_d = vld_q; dat_d = dat_q; adr_d = adr_q; rr_d = rr_q;
    adv   = '0;
    ready = '0;
`ifdef OMEGA_NETWORK_SR_STATS_EN
    nconf = '0;
`endif
    for (int p = 0; p < N; p++) begin
      adv[S][p] = vld_q[S][p] & pop[p];
      if (adv[S][p]) vld_d[S][p] = 1'b0;
    end
    // Walk from the outputs back so each target's "advancing" flag is known before arbitration.
    for (int s = S - 1; s >= 0; s--) begin
      for (int t = 0; t < N; t++) begin
        qu = unshuf(t & ~1);
        ql = unshuf(t | 1);
        ru = vld_q[s][qu] && (adr_q[s][qu][S-1-s] == t[0]);
        rl = vld_q[s][ql] && (adr_q[s][ql][S-1-s] == t[0]);
        if ((ru || rl) && (!vld_q[s+1][t] || adv[s+1][t])) begin
          if (ru && rl) begin
            g = rr_q[s][t] ? ql : qu;
            rr_d[s][t] = ~rr_q[s][t];
`ifdef OMEGA_NETWORK_SR_STATS_EN
            nconf = nconf + 16'd1;
`endif
          end else begin
            g = ru ? qu : ql;
          end
          adv[s][g]     = 1'b1;
          vld_d[s][g]   = 1'b0;
          vld_d[s+1][t] = 1'b1;
          dat_d[s+1][t] = dat_q[s][g];
          if (s + 1 < S) adr_d[s+1][t] = adr_q[s][g];
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      ready[i] = !vld_q[0][i] || adv[0][i];
      if (push[i] && ready[i]) begin
        vld_d[0][i] = 1'b1;
        dat_d[0][i] = d_in[i*WIDTH +: WIDTH];
        adr_d[0][i] = addr_in[i*AW +: AW];
      end
    end
  end

  always_comb begin
    valid = '0;
    d_out = '0;
    for (int p = 0; p < N; p++) begin
      valid[p]                = vld_q[S][p];
      d_out[p*WIDTH +: WIDTH] = dat_q[S][p];
    end
  end

  always_ff @(posedge clk) begin
    dat_q <= dat_d;
    adr_q <= adr_d;
    if (rst) begin
      vld_q <= '0;
      rr_q  <= '0;
    end else begin
      vld_q <= vld_d;
      rr_q  <= rr_d;
    end
  end

`ifdef OMEGA_NETWORK_SR_STATS_EN
  logic [15:0] cnt_q;
  logic [16:0] cnt_sum;
  assign cnt_sum = {1'b0, cnt_q} + {1'b0, nconf};

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  assign conflict_count = cnt_q;
`endif

endmodule

// File: tb/tb_omega_network_sr.sv
// Directed bench for omega_network_sr: scoreboard of accepted packets keyed by destination,
// in-order per source, plus hand-computed latency/backpressure/reset expectations.
module tb_omega_network_sr;
  localparam int N = 8;
  localparam int W = 8;
  localparam int A = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [0:N-1]   push, ready, valid, pop;
  logic [N*W-1:0] d_in, d_out;
  logic [N*A-1:0] addr_in;
`ifdef OMEGA_NETWORK_SR_STATS_EN
  logic [15:0]    conflict_count;
`endif

  int         checks   = 0;
  int         failures = 0;
  logic [23:0] sb[$];   // {dest, src, data} of every accepted, undelivered packet
  int         p0_cnt   = 0;
  logic [7:0] p0_mask  = '0;
  bit         seen_ff  = 1'b0;

  omega_network_sr #(.WIDTH(W), .IN_PORTS(N), .ADDR_WIDTH_PORTS(A)) dut (
    .clk(clk), .rst(rst), .push(push), .d_in(d_in), .addr_in(addr_in),
    .ready(ready), .valid(valid), .d_out(d_out), .pop(pop)
`ifdef OMEGA_NETWORK_SR_STATS_EN
    , .conflict_count(conflict_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A delivered value must be the oldest pending packet of its source for this output.
  task automatic sb_take(input int o, input logic [7:0] v);
    logic [7:0] blocked;
    bit hit;
    blocked = '0;
    hit = 1'b0;
    for (int k = 0; k < sb.size(); k++) begin
      if (sb[k][23:16] == 8'(o)) begin
        if (sb[k][7:0] == v && !blocked[sb[k][10:8]]) begin
          sb.delete(k);
          hit = 1'b1;
          break;
        end
        blocked[sb[k][10:8]] = 1'b1;
      end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL deliver port%0d: got %0h, no pending packet expected in that order", o, v);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      for (int o = 0; o < N; o++) begin
        if (valid[o] && pop[o]) begin
          logic [7:0] v;
          v = d_out[o*W +: W];
          if (v == 8'hFF) seen_ff = 1'b1;
          if (o == 0) begin
            p0_cnt++;
            if (v < 8'd8) p0_mask[v[2:0]] = 1'b1;
          end
          sb_take(o, v);
        end
      end
      for (int i = 0; i < N; i++)
        if (push[i] && ready[i])
          sb.push_back({8'(addr_in[i*A +: A]), 8'(i), d_in[i*W +: W]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [A-1:0] a, input logic [W-1:0] d);
    push[i]            = 1'b1;
    addr_in[i*A +: A]  = a;
    d_in[i*W +: W]     = d;
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while ((sb.size() != 0 || valid != '0) && c < 100) begin
      tick();
      c++;
    end
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  // Push from input i to a as long as ready stays high; returns the number accepted.
  task automatic stream(input int i, input logic [A-1:0] a, input logic [W-1:0] base, output int acc);
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      if (!ready[i]) break;
      drive(i, a, base + W'(acc));
      tick();
      acc++;
    end
    push[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc;
    rst = 1'b1; push = '0; pop = '1; d_in = '0; addr_in = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", 64'(valid), 64'h0);
    chk("rst_ready", 64'(ready), 64'hFF);

    // Identity permutation: conflict-free, S+1 = 4 edges counting the push edge.
    for (int i = 0; i < N; i++) drive(i, A'(i), W'(i));
    tick();
    push = '0;
    chk("lat1_valid", 64'(valid), 64'h0);
    tick(); chk("lat2_valid", 64'(valid), 64'h0);
    tick(); chk("lat3_valid", 64'(valid), 64'h0);
    tick();
    chk("lat4_valid", 64'(valid), 64'hFF);
    chk("lat4_dout", d_out, 64'h0706050403020100);
    tick(); chk("lat5_valid", 64'(valid), 64'h0);
    drain("drain_identity");

    // Hotspot: all inputs to port 0.
    p0_cnt = 0; p0_mask = '0;
    for (int i = 0; i < N; i++) drive(i, 3'd0, W'(i));
    tick();
    push = '0;
    drain("drain_hotspot");
    chk("hot_p0_count", 64'(p0_cnt), 64'd8);
    chk("hot_p0_values", 64'(p0_mask), 64'hFF);

    // Inputs 0 and 4 meet at stage-0 switch 0, both heading upper.
    rst = 1'b1; tick(); rst = 1'b0;
    p0_cnt = 0;
    drive(0, 3'd0, 8'h40);
    drive(4, 3'd0, 8'h44);
    tick();
    push = '0;
    drain("drain_pair");
    chk("pair_p0_count", 64'(p0_cnt), 64'd2);
`ifdef OMEGA_NETWORK_SR_STATS_EN
    chk("pair_conflicts", 64'(conflict_count), 64'd1);
`endif

    // Backpressure: four registers on the path fill, then ready falls.
    pop[5] = 1'b0;
    stream(2, 3'd5, 8'h10, acc);
    chk("bp_accepted", 64'(acc), 64'd4);
    chk("bp_ready2", 64'(ready[2]), 64'd0);
    chk("bp_valid5", 64'(valid[5]), 64'd1);
    chk("bp_head", 64'(d_out[47:40]), 64'h10);
    tick(); tick(); tick();
    chk("bp_hold_ready2", 64'(ready[2]), 64'd0);
    chk("bp_hold_head", 64'(d_out[47:40]), 64'h10);
    pop[5] = 1'b1;
    drain("drain_bp");

    // Push while not ready is ignored.
    pop[6] = 1'b0;
    stream(1, 3'd6, 8'h20, acc);
    chk("nr_accepted", 64'(acc), 64'd4);
    drive(1, 3'd6, 8'hFF);
    tick(); tick(); tick();
    chk("nr_ready1", 64'(ready[1]), 64'd0);
    push = '0;
    pop[6] = 1'b1;
    drain("drain_nr");
    chk("nr_no_ff", 64'(seen_ff), 64'd0);

    // Reset mid-stream discards in-flight packets.
    for (int i = 0; i < N; i++) drive(i, A'(7 - i), 8'h50 + W'(i));
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push = '0;
    chk("mid_rst_valid", 64'(valid), 64'h0);
    chk("mid_rst_ready", 64'(ready), 64'hFF);
    drive(0, 3'd3, 8'hA5);
    tick();
    push = '0;
    chk("a5_lat1", 64'(valid), 64'h0);
    tick(); chk("a5_lat2", 64'(valid), 64'h0);
    tick(); chk("a5_lat3", 64'(valid), 64'h0);
    tick();
    chk("a5_valid", 64'(valid), 64'b0001_0000);
    chk("a5_data", 64'(d_out[31:24]), 64'hA5);
    drain("drain_a5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
